// File: rtl/baby_disp_pkg.sv
// Shared types and glyph geometry for the Baby display pipeline.
package baby_disp_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, READY} render_state_t;

    localparam int GLYPH_W = 16;
    localparam int GLYPH_H = 16;

    typedef struct packed {
        logic [11:0] chr;
        logic [3:0]  px;
    } slot_split_t;

    // Glyphs are 16 pixels wide, so the char/pixel split of a slot is a plain bit slice.
    function automatic slot_split_t glyph_slot_split(input logic [15:0] slot);
        slot_split_t s;
        s.chr = slot[15:4];
        s.px  = slot[3:0];
        return s;
    endfunction

endpackage

// File: rtl/hex_line_renderer_if.sv
// Request, glyph-ROM and pixel-stream signals of the hex line renderer.
interface hex_line_renderer_if #(
    parameter int NCHARS = 8
);
    logic                  start;
    logic [3:0]            line_y;
    logic [4*NCHARS-1:0]   digits;
    logic                  busy;
    logic                  done;
    logic                  line_valid;
    logic [3:0]            glyph_x;
    logic [3:0]            glyph_y;
    logic [3:0]            glyph_no;
    logic                  glyph_pixel;
    logic                  shift_en;
    logic                  pix_out;

    // The master owns the glyph ROM and the raster timing; the renderer is the slave.
    modport master (
        output start, line_y, digits, glyph_pixel, shift_en,
        input  busy, done, line_valid, glyph_x, glyph_y, glyph_no, pix_out
    );

    modport slave (
        input  start, line_y, digits, glyph_pixel, shift_en,
        output busy, done, line_valid, glyph_x, glyph_y, glyph_no, pix_out
    );
endinterface

// File: rtl/pix_line_buffer.sv
// One scanline of pixels: random write port during fetch, sequential read pointer during display.
module pix_line_buffer #(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] i_wr_addr,
    input  logic          i_wr_data,
    input  logic          i_wr_en,
    input  logic          i_rd_clear,
    input  logic          i_rd_adv,
    output logic [AW-1:0] o_rd_ptr,
    output logic          o_rd_data
);
    logic [DEPTH-1:0] r_mem;
    logic [AW-1:0]    r_rd_ptr;

    // NOTE: the buffer is flops, not a RAM macro, so it is cleared on reset; no
    // pixel of an abandoned line can survive a reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem <= '0;
        end else if (i_wr_en) begin
            // NOTE: non-blocking assignment so every flop samples pre-edge values.
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
        end else if (i_rd_clear) begin
            r_rd_ptr <= '0;
        end else if (i_rd_adv) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
        end
    end

    assign o_rd_ptr  = r_rd_ptr;
    assign o_rd_data = r_mem[r_rd_ptr];
endmodule

// File: rtl/hex_line_renderer.sv
// Fetches one glyph row per character from the external dotnos ROM during blanking,
// then streams the assembled scanline out one pixel per shift_en.
module hex_line_renderer
    import baby_disp_pkg::*;
#(
    parameter int NCHARS = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    hex_line_renderer_if.slave bus
);
    localparam int LINE_W = GLYPH_W * NCHARS;
    localparam int SLOT_W = $clog2(LINE_W);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(LINE_W - 1);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_FETCH = FETCH;
    localparam logic [1:0] ST_READY = READY;

    logic [1:0]                   r_state;
    logic [SLOT_W-1:0]            r_slot;
    logic [4*NCHARS-1:0]          r_digits;
    logic [$clog2(GLYPH_W)-1:0]   r_glyph_x;
    logic [$clog2(GLYPH_H)-1:0]   r_glyph_y;
    logic [3:0]                   r_glyph_no;
    logic                         r_done;
    logic                         r_line_valid;

    slot_split_t                  w_split;
    logic [3:0]                   w_next_no;
    logic                         w_load;
    logic                         w_last_read;
    logic                         w_rd_clear;
    logic                         w_rd_adv;
    logic [SLOT_W-1:0]            w_rd_ptr;
    logic                         w_rd_data;

    // A new request is honoured anywhere except mid-fetch, and beats a simultaneous shift.
    assign w_load      = bus.start && (r_state != ST_FETCH);
    assign w_last_read = (r_state == ST_READY) && bus.shift_en && (w_rd_ptr == LAST_SLOT);
    assign w_rd_clear  = w_load || w_last_read;
    assign w_rd_adv    = (r_state == ST_READY) && bus.shift_en && !bus.start;

    // Glyph address for the slot after the current one, registered at this edge.
    assign w_split = glyph_slot_split(16'(r_slot) + 16'd1);

    // NOTE: default first, so no path through the loop can leave w_next_no unassigned (no latch).
    always_comb begin
        w_next_no = '0;
        for (int c = 0; c < NCHARS; c++) begin
            if (int'(w_split.chr) == c) begin
                w_next_no = r_digits[4*(NCHARS-1-c) +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_slot       <= '0;
            r_digits     <= '0;
            r_glyph_x    <= '0;
            r_glyph_y    <= '0;
            r_glyph_no   <= '0;
            r_done       <= 1'b0;
            r_line_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_FETCH: begin
                    if (r_slot == LAST_SLOT) begin
                        r_state      <= ST_READY;
                        r_done       <= 1'b1;
                        r_line_valid <= 1'b1;
                        r_glyph_x    <= '0;
                        r_glyph_y    <= '0;
                        r_glyph_no   <= '0;
                    end else begin
                        r_slot     <= r_slot + SLOT_W'(1);
                        r_glyph_x  <= w_split.px;
                        r_glyph_no <= w_next_no;
                    end
                end
                ST_READY: begin
                    if (w_last_read) begin
                        r_state      <= ST_IDLE;
                        r_line_valid <= 1'b0;
                    end
                end
                ST_IDLE: ;
                default: r_state <= ST_IDLE;
            endcase

            if (w_load) begin
                r_state      <= ST_FETCH;
                r_line_valid <= 1'b0;
                r_slot       <= '0;
                r_digits     <= bus.digits;
                r_glyph_x    <= '0;
                r_glyph_y    <= bus.line_y;
                r_glyph_no   <= bus.digits[4*NCHARS-1 -: 4];
            end
        end
    end

    pix_line_buffer #(
        .DEPTH (LINE_W),
        .AW    (SLOT_W)
    ) u_buf (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_wr_addr  (r_slot),
        .i_wr_data  (bus.glyph_pixel),
        .i_wr_en    (r_state == ST_FETCH),
        .i_rd_clear (w_rd_clear),
        .i_rd_adv   (w_rd_adv),
        .o_rd_ptr   (w_rd_ptr),
        .o_rd_data  (w_rd_data)
    );

    assign bus.busy       = (r_state == ST_FETCH);
    assign bus.done       = r_done;
    assign bus.line_valid = r_line_valid;
    assign bus.glyph_x    = r_glyph_x;
    assign bus.glyph_y    = r_glyph_y;
    assign bus.glyph_no   = r_glyph_no;
    assign bus.pix_out    = r_line_valid & w_rd_data;
endmodule
